priority_encoder_83: RTL and testbench
======================================

PRIORITY_ENCODER_83 -- requirements
Module: priority_encoder_83

Interface
REQ-001 The block SHALL have parameter RR, default 0, meaning 0 = fixed priority and 1 = round-robin priority.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i, input, 8 bits: event request lines, one bit per source, sampled every edge, multi-hot allowed.
REQ-005 The block SHALL have port y, output, 3 bits: registered binary index of the presented source.
REQ-006 The block SHALL have port valid, output, 1 bit: y holds a pending source awaiting acknowledge.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer accepts y; effective only when valid=1.
REQ-008 The block SHALL have port pending, output, 8 bits: registered view of the pending-request register.
REQ-009 The block SHALL have port drop, output, 1 bit: one-cycle pulse when at least one request was lost.
REQ-010 The block SHALL have port drop_cnt, output, 8 bits: saturating count of edges on which a request was lost.

Function
REQ-011 The pending register SHALL update each edge as pend_next = (pend & ~clr) | i, where clr = onehot(y) when valid & ack, else 0.
REQ-012 When a request bit is set on the same edge as its clear, set SHALL win: the bit stays pending and is not counted as lost.
REQ-013 A lost request SHALL be any i bit that is high while the same pend bit is already 1 and is not being cleared on that edge.
REQ-014 On an edge with at least one lost request, drop SHALL be 1 for the next cycle and drop_cnt SHALL increment by 1 (not by the number of lost bits), saturating at 255.
REQ-015 The block SHALL implement two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-016 In IDLE, if pend != 0 at an edge, the block SHALL load y = sel(pend) and enter PRESENT; otherwise it SHALL stay in IDLE.
REQ-017 A request on i at edge k SHALL be visible on pending after edge k and SHALL be presented (valid=1) after edge k+1 when the block is idle; fixed latency is 2 edges.
REQ-018 In PRESENT without ack, y and valid SHALL hold stable regardless of new i activity, including higher-priority arrivals.
REQ-019 In PRESENT with ack, let rem = pend & ~onehot(y). If rem != 0, the block SHALL load y = sel(rem) and stay in PRESENT, giving back-to-back presentation with no bubble. Otherwise it SHALL go to IDLE with valid=0.
REQ-020 A request arriving on the ack edge SHALL NOT join the selection at that edge; it enters pend and is considered from the next edge.
REQ-021 ack while valid=0 SHALL be ignored and SHALL have no state effect.
REQ-022 With RR=0, sel(v) SHALL return the highest set bit index, so bit 7 has the highest priority.
REQ-023 With RR=1, sel(v) SHALL scan v descending starting at (last-1) mod 8 with wrap-around, where last is the index of the most recently acknowledged y.
REQ-024 With RR=1, last SHALL reset to 0, so the first scan starts at bit 7.
REQ-025 With RR=1, last SHALL update only on an accepted ack.
REQ-026 sel SHALL be evaluated only when its argument is nonzero.
REQ-027 y SHALL be the binary encoding of the selected bit; y=3'b000 with valid=0 means no request.

Reset
REQ-028 With rst=1 at an edge, the block SHALL clear pend, set y=0, valid=0, drop=0, drop_cnt=0 and last=0, and enter IDLE; i and ack at that edge SHALL be ignored.
REQ-029 Reset asserted in PRESENT mid-handshake SHALL discard the presented and all pending requests; the first post-reset presentation SHALL occur 2 edges after a new i pulse.

Verification
REQ-030 The bench SHALL cover single event: rst, then i=8'h10 for 1 cycle -> pending=8'h10 after 1 edge; valid=1, y=4 after 2 edges; ack 1 cycle -> valid=0, pending=0.
REQ-031 The bench SHALL cover fixed-priority burst: RR=0, i=8'hA5 for 1 cycle, ack held high -> y sequence 7,5,2,0 on consecutive cycles with valid=1 throughout, then valid=0.
REQ-032 The bench SHALL cover round-robin: RR=1, i=8'h81 pulse, ack held -> y=7 then 0; then i=8'h81 again -> y=7 then 0; repeat with 8'h82 after last=7 -> y=1 first.
REQ-033 The bench SHALL cover hold and collision: valid=1, y=3, no ack, i=8'h08 -> drop=1 next cycle, drop_cnt=1, y stays 3. Then ack together with i=8'h08 -> drop=0, bit 3 re-presented after the next edge.
REQ-034 The bench SHALL cover saturation: force 300 collision edges -> drop_cnt=255 and stays.
REQ-035 The bench SHALL cover reset mid-operation: pending=8'hFF, valid=1, rst for 1 edge -> all outputs 0; ack the following cycle has no effect.

Source files
------------

// File: rtl/priority_encoder_83_if.sv
// rtl/priority_encoder_83_if.sv - request/present/acknowledge bus of the 8:3 priority encoder
interface priority_encoder_83_if;
  logic [7:0] i;
  logic       ack;
  logic [2:0] y;
  logic       valid;
  logic [7:0] pending;
  logic       drop;
  logic [7:0] drop_cnt;

  modport master (
    output i, ack,
    input  y, valid, pending, drop, drop_cnt
  );

  modport slave (
    input  i, ack,
    output y, valid, pending, drop, drop_cnt
  );
endinterface

// File: rtl/priority_encoder_83.sv
// rtl/priority_encoder_83.sv - pending-request 8:3 encoder with fixed or round-robin selection
module priority_encoder_83 #(
  parameter int RR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_83_if.slave  bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state;
  logic [7:0] pend;
  logic [2:0] y;
  logic [2:0] last;
  logic       drop;
  logic [7:0] drop_cnt;

  logic [7:0] y_hot;
  logic [7:0] clr;
  logic [7:0] lost;
  logic [7:0] rem;

  // Fixed mode: highest index wins. Round-robin: scan down from lst-1 with wrap.
  function automatic logic [2:0] sel(input logic [7:0] v, input logic [2:0] lst);
    logic [2:0] idx;
    logic       found;
    sel   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (RR == 0) idx = 3'd7 - k[2:0];
      else         idx = lst - 3'd1 - k[2:0];
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    y_hot = 8'b1 << y;
    clr   = (state == PRESENT && bus.ack) ? y_hot : 8'h00;
    lost  = bus.i & pend & ~clr;
    rem   = pend & ~y_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= 8'h00;
      y        <= 3'd0;
      last     <= 3'd0;
      drop     <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      // A bit set on its own clear edge stays pending and is not counted as lost.
      pend <= (pend & ~clr) | bus.i;
      drop <= |lost;
      if (|lost && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (|pend) begin
            y     <= sel(pend, last);
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            last <= y;
            if (|rem) begin
              y <= sel(rem, y);
            end else begin
              y     <= 3'd0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y        = y;
  assign bus.valid    = (state == PRESENT);
  assign bus.pending  = pend;
  assign bus.drop     = drop;
  assign bus.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_priority_encoder_83.sv
// tb/tb_priority_encoder_83.sv - directed self-checking bench for fixed and round-robin encoders
module tb_priority_encoder_83;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   n_checks = 0;
  int   n_fail   = 0;

  priority_encoder_83_if f ();
  priority_encoder_83_if r ();

  priority_encoder_83 #(.RR(0)) u_fixed (.clk(clk), .rst(rst0), .bus(f));
  priority_encoder_83 #(.RR(1)) u_rr    (.clk(clk), .rst(rst1), .bus(r));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    f.i = 8'h00; f.ack = 1'b0;
    r.i = 8'h00; r.ack = 1'b0;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    check("rst_y",        f.y, 0);
    check("rst_valid",    f.valid, 0);
    check("rst_pending",  f.pending, 0);
    check("rst_drop",     f.drop, 0);
    check("rst_drop_cnt", f.drop_cnt, 0);

    // single event
    f.i = 8'h10; tick(); f.i = 8'h00;
    check("single_pend",   f.pending, 8'h10);
    check("single_vlat",   f.valid, 0);
    tick();
    check("single_valid",  f.valid, 1);
    check("single_y",      f.y, 4);
    f.ack = 1'b1; tick(); f.ack = 1'b0;
    check("single_done_v", f.valid, 0);
    check("single_done_p", f.pending, 0);

    // fixed-priority burst with ack held
    f.i = 8'hA5; tick(); f.i = 8'h00;
    check("burst_pend", f.pending, 8'hA5);
    f.ack = 1'b1;
    tick(); check("burst_y7", f.y, 7); check("burst_v7", f.valid, 1);
    tick(); check("burst_y5", f.y, 5); check("burst_v5", f.valid, 1);
    tick(); check("burst_y2", f.y, 2); check("burst_v2", f.valid, 1);
    tick(); check("burst_y0", f.y, 0); check("burst_v0", f.valid, 1);
    tick(); check("burst_end", f.valid, 0);
    f.ack = 1'b0;

    // hold and collision
    f.i = 8'h08; tick(); f.i = 8'h00; tick();
    check("hold_y", f.y, 3);
    check("hold_v", f.valid, 1);
    f.i = 8'h08; tick(); f.i = 8'h00;
    check("coll_drop", f.drop, 1);
    check("coll_cnt",  f.drop_cnt, 1);
    check("coll_y",    f.y, 3);
    tick();
    check("coll_drop_clr", f.drop, 0);
    f.ack = 1'b1; f.i = 8'h08; tick(); f.ack = 1'b0; f.i = 8'h00;
    check("ackset_drop", f.drop, 0);
    check("ackset_cnt",  f.drop_cnt, 1);
    check("ackset_pend", f.pending, 8'h08);
    check("ackset_v",    f.valid, 0);
    tick();
    check("repres_v", f.valid, 1);
    check("repres_y", f.y, 3);

    // saturation
    f.i = 8'h08;
    repeat (300) tick();
    check("sat_cnt",  f.drop_cnt, 255);
    check("sat_drop", f.drop, 1);
    f.i = 8'h00; tick();
    check("sat_hold", f.drop_cnt, 255);
    check("sat_drop_clr", f.drop, 0);

    // higher-priority arrival does not disturb presentation, then reset mid-handshake
    f.i = 8'hFF; tick(); f.i = 8'h00;
    check("mid_pend", f.pending, 8'hFF);
    check("mid_y",    f.y, 3);
    rst0 = 1'b1; f.ack = 1'b1; f.i = 8'h55; tick(); rst0 = 1'b0; f.i = 8'h00;
    check("mrst_y",   f.y, 0);
    check("mrst_v",   f.valid, 0);
    check("mrst_p",   f.pending, 0);
    check("mrst_d",   f.drop, 0);
    check("mrst_cnt", f.drop_cnt, 0);
    tick(); f.ack = 1'b0;
    check("idle_ack_v", f.valid, 0);
    check("idle_ack_p", f.pending, 0);
    check("idle_ack_y", f.y, 0);
    f.i = 8'h02; tick(); f.i = 8'h00;
    check("post_lat", f.valid, 0);
    tick();
    check("post_v", f.valid, 1);
    check("post_y", f.y, 1);

    // round-robin
    r.i = 8'h81; tick(); r.i = 8'h00; r.ack = 1'b1;
    tick(); check("rr1_y7", r.y, 7); check("rr1_v7", r.valid, 1);
    tick(); check("rr1_y0", r.y, 0); check("rr1_v0", r.valid, 1);
    tick(); check("rr1_end", r.valid, 0);
    r.i = 8'h81; tick(); r.i = 8'h00;
    tick(); check("rr2_y7", r.y, 7);
    tick(); check("rr2_y0", r.y, 0); check("rr2_v0", r.valid, 1);
    tick(); check("rr2_end", r.valid, 0);
    r.ack = 1'b0;
    r.i = 8'h80; tick(); r.i = 8'h00; tick();
    check("rr3_y7", r.y, 7);
    r.ack = 1'b1; tick(); r.ack = 1'b0;
    check("rr3_end", r.valid, 0);
    r.i = 8'h82; tick(); r.i = 8'h00; tick();
    check("rr4_y1", r.y, 1);
    check("rr4_v1", r.valid, 1);
    r.ack = 1'b1; tick();
    check("rr4_y7", r.y, 7);
    tick(); r.ack = 1'b0;
    check("rr4_end", r.valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
